// File: rtl/wr_pack_fifo_feeder_pkg.sv
// Shared constants and helpers for the 16-to-128 write-side packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wr_pack_fifo_feeder_pkg;

    localparam int unsigned DEF_IN_WIDTH  = 16;
    localparam int unsigned DEF_OUT_WIDTH = 128;
    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam logic [15:0] DEF_PAD_VALUE = 16'h0000;

    // Samples per packed word.
    function automatic int unsigned pack_ratio(input int unsigned out_w, input int unsigned in_w);
        return out_w / in_w;
    endfunction

    // Lane index width; kept at least one bit so a degenerate ratio still elaborates.
    function automatic int unsigned lane_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/wr_pack_fifo_feeder_if.sv
// Sample-in / packed-word-out bundle between a sample source, the packer and a wide FIFO.
// Latency: n/a (wires only).
// Backpressure: in_ready from the packer, fifo_full from the FIFO write side.
interface wr_pack_fifo_feeder_if
    import wr_pack_fifo_feeder_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 fifo_wr_en;
    logic [OUT_WIDTH-1:0] fifo_wr_data;
    logic                 fifo_full;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic                 frame_done;

    // master: sample source plus FIFO status; slave: the packer itself.
    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data, word_cnt, frame_done
    );
    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data, word_cnt, frame_done
    );
endinterface

// File: rtl/wr_pack_out_reg.sv
// One-entry holding register for a packed word plus its frame-last flag.
// Latency: word visible on wr_dat_o the cycle after load; written the same cycle if not full.
// Backpressure: holds while fifo_full_i; in_rdy_o low only when full and occupied.
// Ports: clk/rst_n; load_*_i new word; fifo_full_i; in_rdy_o, wr_en_o, wr_dat_o, wr_last_o.
module wr_pack_out_reg #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_vld_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             load_last_i,
    input  logic             fifo_full_i,
    output logic             in_rdy_o,
    output logic             wr_en_o,
    output logic [WIDTH-1:0] wr_dat_o,
    output logic             wr_last_o
);
    logic             vld_q, vld_d;
    logic             last_q;
    logic [WIDTH-1:0] dat_q;

    // Gating with rst_n keeps a held word from escaping during the reset cycle.
    assign wr_en_o   = vld_q && !fifo_full_i && rst_n;
    assign in_rdy_o  = !vld_q || !fifo_full_i;
    assign wr_dat_o  = dat_q;
    assign wr_last_o = last_q;

    // A load only happens when in_rdy_o is high, so it never overwrites an unwritten word;
    // load wins over drain so back-to-back words keep the register full.
    always_comb begin
        vld_d = vld_q;
        if (load_vld_i) begin
            vld_d = 1'b1;
        end else if (wr_en_o) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (load_vld_i) begin
                dat_q  <= load_dat_i;
                last_q <= load_last_i;
            end
        end
    end
endmodule

// File: rtl/wr_pack_fifo_feeder.sv
// Packs RATIO narrow samples (lane 0 = first) into one wide word and writes it to a FIFO.
// Latency: word written the cycle after its completing sample is accepted (if FIFO not full).
// Backpressure: in_ready drops only while a completed word is held against fifo_full.
// Ports: clk, rst_n (sync, active low); bus = sample in, FIFO write out, word_cnt, frame_done.
module wr_pack_fifo_feeder
    import wr_pack_fifo_feeder_pkg::*;
#(
    parameter int unsigned         IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned         OUT_WIDTH = DEF_OUT_WIDTH,
    parameter logic [IN_WIDTH-1:0] PAD_VALUE = IN_WIDTH'(DEF_PAD_VALUE),
    parameter int unsigned         CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    wr_pack_fifo_feeder_if.slave  bus
);
    localparam int unsigned          RATIO     = pack_ratio(OUT_WIDTH, IN_WIDTH);
    localparam int unsigned          LANE_W    = lane_width(RATIO);
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [OUT_WIDTH-1:0] PAD_WORD  = {RATIO{PAD_VALUE}};

    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] word_ins;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 in_rdy, accept, complete;
    logic                 wr_en, wr_last;

    assign accept   = bus.in_valid && in_rdy;
    assign complete = accept && ((lane_q == LAST_LANE) || bus.in_last);

    // Accumulator with the incoming sample dropped into the current lane; lanes not yet
    // written still hold PAD_VALUE, so a short (flushed) word is already padded.
    always_comb begin
        word_ins = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_q == LANE_W'(k)) begin
                word_ins[k*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            end
        end
    end

    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (complete) begin
            lane_d = '0;
            acc_d  = PAD_WORD;
        end else if (accept) begin
            lane_d = lane_q + LANE_W'(1);
            acc_d  = word_ins;
        end
    end

    // The last word of a frame clears the count rather than bumping it.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = wr_en && wr_last;
        if (wr_en) begin
            if (wr_last) begin
                cnt_d = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q <= '0;
            acc_q  <= PAD_WORD;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    wr_pack_out_reg #(
        .WIDTH (OUT_WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_vld_i  (complete),
        .load_dat_i  (word_ins),
        .load_last_i (bus.in_last),
        .fifo_full_i (bus.fifo_full),
        .in_rdy_o    (in_rdy),
        .wr_en_o     (wr_en),
        .wr_dat_o    (bus.fifo_wr_data),
        .wr_last_o   (wr_last)
    );

    assign bus.in_ready   = in_rdy;
    assign bus.fifo_wr_en = wr_en;
    assign bus.word_cnt   = cnt_q;
    assign bus.frame_done = done_q;
endmodule
